// File: rtl/msrh_icache_miss_unit.sv
// Non-blocking I-cache miss handler: tracks up to ENTRIES line fills, merges misses to the
// same line, issues them to L2 in index order and retires them by tag with a registered refill.
module msrh_icache_miss_unit #(
    parameter int         ENTRIES      = 4,
    parameter int         PADDR_W      = 56,
    parameter int         VADDR_W      = 39,
    parameter int         LINE_W       = 128,
    parameter int         L2_CMD_TAG_W = 8,
    parameter logic [1:0] UPPER_TAG    = 2'b00
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_miss_valid,
    input  logic [PADDR_W-1:0]      i_miss_paddr,
    input  logic [VADDR_W-1:0]      i_miss_vaddr,
    output logic                    o_miss_ready,
    input  logic                    i_fence_i,
    output logic                    o_l2_req_valid,
    input  logic                    i_l2_req_ready,
    output logic [PADDR_W-1:0]      o_l2_req_paddr,
    output logic [L2_CMD_TAG_W-1:0] o_l2_req_tag,
    input  logic                    i_l2_resp_valid,
    input  logic [L2_CMD_TAG_W-1:0] i_l2_resp_tag,
    input  logic [LINE_W-1:0]       i_l2_resp_data,
    output logic                    o_refill_valid,
    output logic [VADDR_W-1:0]      o_refill_vaddr,
    output logic [LINE_W-1:0]       o_refill_data,
    output logic                    o_full,
    output logic                    o_busy
);

    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int LA_W   = PADDR_W - OFF;
    localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int TIDX_W = L2_CMD_TAG_W - 2;

    localparam logic [1:0] ST_FREE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // L2 handshake: a request transfers on a cycle where o_l2_req_valid and i_l2_req_ready
    // are both high; once raised, valid and its payload stay put until that cycle.
    logic [1:0]         entry_state [ENTRIES];
    logic [LA_W-1:0]    entry_line  [ENTRIES];
    logic [VADDR_W-1:0] entry_vaddr [ENTRIES];
    logic [ENTRIES-1:0] entry_drop;

    logic [ENTRIES-1:0] is_free, is_req, is_wait, line_hit, resp_hit;
    logic [IDX_W-1:0]   free_idx, req_first, req_sel, req_sel_q, resp_idx;
    logic [LA_W-1:0]    miss_line;
    logic               any_hit, alloc, req_fire, req_hold_q, resp_fire, resp_keep;

    assign miss_line = i_miss_paddr[PADDR_W-1:OFF];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            is_free[i]  = (entry_state[i] == ST_FREE);
            is_req[i]   = (entry_state[i] == ST_REQ);
            is_wait[i]  = (entry_state[i] == ST_WAIT);
            line_hit[i] = !is_free[i] && !entry_drop[i] && (entry_line[i] == miss_line);
            resp_hit[i] = i_l2_resp_valid && is_wait[i]
                          && (i_l2_resp_tag[L2_CMD_TAG_W-1 -: 2] == UPPER_TAG)
                          && (i_l2_resp_tag[TIDX_W-1:0] == TIDX_W'(i));
        end
    end

    // Lowest-index priority encoders; at most one entry can match a response tag.
    always_comb begin
        free_idx  = '0;
        req_first = '0;
        resp_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (is_free[i])  free_idx  = IDX_W'(i);
            if (is_req[i])   req_first = IDX_W'(i);
            if (resp_hit[i]) resp_idx  = IDX_W'(i);
        end
    end

    assign any_hit        = |line_hit;
    assign o_miss_ready   = !i_fence_i && (any_hit || (|is_free));
    assign alloc          = i_miss_valid && o_miss_ready && !any_hit;
    assign o_full         = &(~is_free);
    assign o_busy         = |(~is_free);

    assign o_l2_req_valid = |is_req;
    assign req_sel        = req_hold_q ? req_sel_q : req_first;
    assign req_fire       = o_l2_req_valid && i_l2_req_ready;
    assign o_l2_req_paddr = {entry_line[req_sel], {OFF{1'b0}}};
    assign o_l2_req_tag   = {UPPER_TAG, TIDX_W'(req_sel)};

    // A response in the fence cycle is dropped even though its drop bit is still clear.
    assign resp_fire      = |resp_hit;
    assign resp_keep      = resp_fire && !entry_drop[resp_idx] && !i_fence_i;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_state[i] <= ST_FREE;
                entry_drop[i]  <= 1'b0;
            end
            req_hold_q     <= 1'b0;
            req_sel_q      <= '0;
            o_refill_valid <= 1'b0;
            o_refill_vaddr <= '0;
            o_refill_data  <= '0;
        end else begin
            req_hold_q <= o_l2_req_valid && !i_l2_req_ready;
            req_sel_q  <= req_sel;
            for (int i = 0; i < ENTRIES; i++) begin
                if (alloc && (free_idx == IDX_W'(i))) begin
                    entry_state[i] <= ST_REQ;
                    entry_drop[i]  <= 1'b0;
                end else begin
                    if (req_fire && (req_sel == IDX_W'(i))) entry_state[i] <= ST_WAIT;
                    if (resp_hit[i])                        entry_state[i] <= ST_FREE;
                    if (i_fence_i && !is_free[i])           entry_drop[i]  <= 1'b1;
                end
            end
            o_refill_valid <= resp_keep;
            if (resp_keep) begin
                o_refill_vaddr <= entry_vaddr[resp_idx];
                o_refill_data  <= i_l2_resp_data;
            end
        end
    end

    // Address payload needs no reset: it is only observed while its entry is occupied.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (alloc && (free_idx == IDX_W'(i))) begin
                entry_line[i]  <= miss_line;
                entry_vaddr[i] <= i_miss_vaddr;
            end
        end
    end

endmodule

// File: doc/msrh_icache_miss_unit.md
Name: msrh_icache_miss_unit

Overview:
- Non-blocking instruction-cache miss handler with ENTRIES outstanding line fills; generalises the single-outstanding ICInit/ICReq/ICResp miss machine.
- Sits between the I-cache S2 miss detection and the L2 request/response channel.
- Tracks, de-duplicates and issues line misses, matches out-of-order L2 responses by tag, and emits registered refill writes to the tag/data arrays.
- Handles fence.i by draining in-flight fills without writing them.

Parameters:
- ENTRIES, 4, number of miss entries; 1 ≤ ENTRIES ≤ 2**(L2_CMD_TAG_W-2).
- PADDR_W, 56, physical address width.
- VADDR_W, 39, virtual address width.
- LINE_W, 128, refill line width in bits; line offset bits OFF = clog2(LINE_W/8).
- L2_CMD_TAG_W, 8, L2 tag width.
- UPPER_TAG, 2'b00, I-cache requester ID in the tag's upper 2 bits.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_miss_valid  in  1  S2 miss request
- i_miss_paddr  in  PADDR_W  miss physical address
- i_miss_vaddr  in  VADDR_W  miss virtual address (refill index/tag)
- o_miss_ready  out  1  miss accepted (allocated or merged)
- i_fence_i  in  1  invalidate: drop all in-flight fills
- o_l2_req_valid  out  1  L2 read request
- i_l2_req_ready  in  1  L2 accepts request
- o_l2_req_paddr  out  PADDR_W  line-aligned address (low OFF bits zero)
- o_l2_req_tag  out  L2_CMD_TAG_W  {UPPER_TAG, entry index zero-extended}
- i_l2_resp_valid  in  1  L2 response
- i_l2_resp_tag  in  L2_CMD_TAG_W  response tag
- i_l2_resp_data  in  LINE_W  line data
- o_refill_valid  out  1  write line to arrays
- o_refill_vaddr  out  VADDR_W  vaddr of the refilled line (entry's stored vaddr)
- o_refill_data  out  LINE_W  refill data
- o_full  out  1  no free entry
- o_busy  out  1  any entry not Free

Behaviour:
- **Reset** (i_reset high at a clock edge):
  - All entries go to Free with drop bit = 0.
  - o_refill_valid = 0, o_refill_vaddr = 0, o_refill_data = 0.
  - Consequently o_l2_req_valid = 0, o_full = 0, o_busy = 0.
  - Reset asserted mid-operation abandons outstanding fills; responses arriving after reset are ignored, because no entry is in WaitResp.
- **Entry state machine**: Free -> ReqPending -> WaitResp -> Free. Each entry stores paddr line address, vaddr and a drop bit.
- **Line match**: paddr[PADDR_W-1:OFF] equality against a non-Free entry with drop = 0.
- **o_miss_ready** = !i_fence_i & (line match | any Free entry). Combinational, independent of i_miss_valid.
- **Accept** (i_miss_valid & o_miss_ready):
  - If a line match exists, the miss merges: no state change, no new L2 request.
  - Otherwise the lowest-index Free entry moves to ReqPending and captures paddr and vaddr.
- **L2 request arbitration**:
  - o_l2_req_valid = any ReqPending.
  - The selected entry is the lowest-index ReqPending, except that once o_l2_req_valid is high and i_l2_req_ready is low, the selection and payload are held until the handshake completes. Valid is never withdrawn.
  - On handshake the entry moves to WaitResp.
- **Response**:
  - A response is accepted when i_l2_resp_valid, tag[L2_CMD_TAG_W-1 -: 2] == UPPER_TAG, the index < ENTRIES, and that entry is in WaitResp. There is no ready; the response is always consumed.
  - The entry moves to Free at that edge.
  - If the entry's drop bit is 0, the next cycle drives o_refill_valid = 1 with that entry's vaddr and the response data. The refill latency is exactly 1 cycle.
  - Any other response (foreign upper tag, index out of range, entry not in WaitResp) is ignored.
- **fence_i**: in the cycle i_fence_i is high, every non-Free entry's drop bit is set.
  - Dropped entries still complete their L2 request and response but produce no refill.
  - A response arriving in the same cycle as i_fence_i is also dropped: no refill is issued.
  - An entry allocated after fence_i starts with drop = 0.
- **Entry reuse**: an entry freed this cycle is not allocatable until the next cycle; o_full/o_miss_ready reflect registered state.
- **Simultaneous events**: accept, request handshake and response may all occur in one cycle on different entries. A merge against an entry whose response arrives the same cycle is allowed; the refill covers it.
- **Full**: o_full = all entries non-Free. When full, only merging misses are accepted.

Test Plan:
- **Single miss**:
  - Stimulus: i_miss paddr 0x8000_0014, vaddr 0x1000_0014.
  - Required: o_l2_req_paddr 0x8000_0010, tag 0x00; L2 ready at once; response 3 cycles later with data D.
  - Required: the next cycle gives o_refill_valid = 1, vaddr 0x1000_0014, data D; then o_busy = 0.
- **Merge**:
  - Stimulus: two misses to 0x8000_0040 and 0x8000_004C in consecutive cycles.
  - Required: exactly one L2 request, both o_miss_ready = 1, one refill.
- **Full / out-of-order** (ENTRIES = 4):
  - Stimulus: 4 distinct lines are allocated, after which the required o_full = 1 and a 5th distinct miss is rejected.
  - Stimulus: responses return with tags 3, 0, 2, 1.
  - Required: 4 refills in that order with the matching vaddrs.
- **Backpressure**:
  - Stimulus: i_l2_req_ready = 0 for 5 cycles while entries 0 and 1 are pending.
  - Required: o_l2_req_tag stays 0 and the paddr is stable; entry 1 issues after entry 0's handshake.
- **fence_i**:
  - Stimulus: fence_i pulses with 2 entries in WaitResp and 1 in ReqPending.
  - Required: o_miss_ready = 0 that cycle; all 3 requests/responses complete with no o_refill_valid.
  - Stimulus: a new miss afterwards.
  - Required: it refills normally.
- **Reset and stray responses**:
  - Stimulus: i_reset with 2 entries outstanding.
  - Required: o_busy = 0 next cycle; late responses with tags 0/1 give no refill.
  - Stimulus: a response with upper tag 2'b01 at any time.
  - Required: ignored.
